// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised oversampling UART receiver. Deserialises the asynchronous rx
// line into DATA_BITS-wide words (LSB first), timed by a shared b_tick strobe
// running at OVERSAMPLE x baud. Detects false starts, checks STOP_BITS stop
// bits and, optionally, a parity bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits and parity_err is checked
//   undefined -> no parity stage, parity_err is tied to 0
//
// Ports
//   clk        in   1          system clock
//   rst        in   1          synchronous, active-high reset
//   rx         in   1          asynchronous serial line, idle high
//   b_tick     in   1          one-clk strobe at OVERSAMPLE x baud
//   rx_data    out  DATA_BITS  last completed word, held until next completion
//   rx_done    out  1          one-clk pulse; rx_data and flags valid
//   frame_err  out  1          last frame had a low stop bit (held)
//   parity_err out  1          last frame had a parity mismatch (held)
//   busy       out  1          receiver is inside a frame
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    // Sample points: middle of the start bit, then one full bit period apart.
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser (reset to the idle level so reset never looks
    // like a start bit)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_e               state_q,      state_d;
    logic [TickW-1:0]     tick_q,       tick_d;
    // Counts data bits in StData and stop bits in StStop.
    logic [BitW-1:0]      bit_q,        bit_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 ferr_acc_q,   ferr_acc_d;
    // Cleared after a framing error so a line held in break cannot start
    // a new frame until it has been seen high again.
    logic                 armed_q,      armed_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 done_q,       done_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 ferr_next;

`ifdef UART_RX_PARITY_EN
    logic                 perr_acc_q,   perr_acc_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ferr_acc_d  = ferr_acc_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        // Stop-bit error including the sample taken on this tick.
        ferr_next   = ferr_acc_q | ~rx_s_q;
`ifdef UART_RX_PARITY_EN
        perr_acc_d   = perr_acc_q;
        parity_err_d = parity_err_q;
`endif

        if (b_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end

                StStart: begin
                    if (tick_q == TickMid) begin
                        if (rx_s_q) begin
                            // Line went back high before mid start bit: glitch.
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end

                StData: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BitLast) begin
                            bit_d      = '0;
                            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d    = StParity;
`else
                            state_d    = StStop;
`endif
                        end else begin
                            bit_d = bit_q + BitW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick_q == TickLast) begin
                        tick_d     = '0;
                        bit_d      = '0;
                        ferr_acc_d = 1'b0;
                        perr_acc_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD[0];
                        state_d    = StStop;
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
`endif

                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        if (bit_q == StopLast) begin
                            state_d     = StIdle;
                            done_d      = 1'b1;
                            rx_data_d   = shift_q;
                            frame_err_d = ferr_next;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = perr_acc_q;
`endif
                            if (ferr_next) begin
                                armed_d = 1'b0;
                            end
                        end else begin
                            bit_d      = bit_q + BitW'(1);
                            ferr_acc_d = ferr_next;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            armed_q     <= 1'b1;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ferr_acc_q  <= ferr_acc_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_acc_q   <= perr_acc_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    // PARITY_ODD only matters when the parity stage exists.
    logic unused_parity_odd;
    assign unused_parity_odd = ^PARITY_ODD;
    assign parity_err        = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_done   = done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int ClkPerBit = 64;  // OVERSAMPLE 16 x 4 clk per tick

`ifdef UART_RX_PARITY_EN
    localparam bit ParOn = 1'b1;
`else
    localparam bit ParOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tick_div = '0;
    logic       b_tick;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] rx_data_a;
    logic       rx_done_a, frame_err_a, parity_err_a, busy_a;
    logic [6:0] rx_data_b;
    logic       rx_done_b, frame_err_b, parity_err_b, busy_b;

    always #5 clk = ~clk;
    always @(posedge clk) tick_div <= tick_div + 2'd1;
    assign b_tick = (tick_div == 2'd0);

    uart_rx_param #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_a),
        .b_tick    (b_tick),
        .rx_data   (rx_data_a),
        .rx_done   (rx_done_a),
        .frame_err (frame_err_a),
        .parity_err(parity_err_a),
        .busy      (busy_a)
    );

    uart_rx_param #(
        .DATA_BITS (7),
        .OVERSAMPLE(16),
        .STOP_BITS (2),
        .PARITY_ODD(0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_b),
        .b_tick    (b_tick),
        .rx_data   (rx_data_b),
        .rx_done   (rx_done_b),
        .frame_err (frame_err_b),
        .parity_err(parity_err_b),
        .busy      (busy_b)
    );

    // Completed-frame capture, sampled away from the active edge.
    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rec_t;

    rec_t got_a[$];
    rec_t got_b[$];
    int   consec_a = 0;
    logic prev_done_a = 1'b0;

    always @(negedge clk) begin
        if (rx_done_a) got_a.push_back({frame_err_a, parity_err_a, rx_data_a});
        if (rx_done_a && prev_done_a) consec_a <= consec_a + 1;
        prev_done_a <= rx_done_a;
        if (rx_done_b) got_b.push_back({frame_err_b, parity_err_b, 1'b0, rx_data_b});
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_a(input logic v);
        rx_a = v;
        clk_wait(ClkPerBit);
    endtask

    task automatic bit_b(input logic v);
        rx_b = v;
        clk_wait(ClkPerBit);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stop);
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(d[i]);
        bit_a(stop);
    endtask

    task automatic frame_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
        bit_b(1'b0);
        for (int i = 0; i < 7; i++) bit_b(d[i]);
        if (ParOn) bit_b(par);
        bit_b(s1);
        bit_b(s2);
    endtask

    // Expect exactly one captured frame on instance A with given contents.
    task automatic expect_a(input string name, input logic [7:0] d, input logic ferr);
        rec_t r;
        check({name, " count"}, got_a.size(), 1);
        if (got_a.size() > 0) begin
            r = got_a.pop_front();
            check({name, " data"}, int'(r.data), int'(d));
            check({name, " frame_err"}, int'(r.ferr), int'(ferr));
        end
        got_a.delete();
    endtask

    task automatic expect_b(input string name, input logic [6:0] d, input logic ferr,
                            input logic perr);
        rec_t r;
        check({name, " count"}, got_b.size(), 1);
        if (got_b.size() > 0) begin
            r = got_b.pop_front();
            check({name, " data"}, int'(r.data), int'({1'b0, d}));
            check({name, " frame_err"}, int'(r.ferr), int'(ferr));
            check({name, " parity_err"}, int'(r.perr), int'(perr));
        end
        got_b.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rec_t r;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b0};

        // Reset state
        rst = 1'b1;
        clk_wait(3);
        check("reset rx_data", int'(rx_data_a), 0);
        check("reset rx_done", int'(rx_done_a), 0);
        check("reset frame_err", int'(frame_err_a), 0);
        check("reset parity_err", int'(parity_err_a), 0);
        check("reset busy", int'(busy_a), 0);
        rst = 1'b0;
        clk_wait(2 * ClkPerBit);

        // Table of single frames, each followed by two idle bits
        for (int i = 0; i < 6; i++) begin
            frame_a(vecs[i].data, vecs[i].stop);
            bit_a(1'b1);
            bit_a(1'b1);
            check($sformatf("vec%0d busy", i), int'(busy_a), 0);
            check($sformatf("vec%0d held data", i), int'(rx_data_a), int'(vecs[i].exp_data));
            expect_a($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr);
        end

        // Short low glitch: 5 ticks
        rx_a = 1'b0;
        clk_wait(16);
        check("glitch busy high", int'(busy_a), 1);
        clk_wait(4);
        rx_a = 1'b1;
        clk_wait(2 * ClkPerBit);
        check("glitch busy low", int'(busy_a), 0);
        check("glitch no done", got_a.size(), 0);
        check("glitch data held", int'(rx_data_a), 'h81);
        got_a.delete();

        // Bad stop followed by a 40-bit break, then a good frame
        frame_a(8'hA3, 1'b0);
        clk_wait(40 * ClkPerBit);
        check("break not busy", int'(busy_a), 0);
        expect_a("break frame", 8'hA3, 1'b1);
        bit_a(1'b1);
        bit_a(1'b1);
        check("break no extra", got_a.size(), 0);
        frame_a(8'h3C, 1'b1);
        bit_a(1'b1);
        bit_a(1'b1);
        expect_a("after break", 8'h3C, 1'b0);

        // Back-to-back frames, no idle gap
        frame_a(8'h00, 1'b1);
        frame_a(8'hFF, 1'b1);
        bit_a(1'b1);
        bit_a(1'b1);
        check("b2b count", got_a.size(), 2);
        if (got_a.size() == 2) begin
            r = got_a.pop_front();
            check("b2b first", int'(r.data), 'h00);
            r = got_a.pop_front();
            check("b2b second", int'(r.data), 'hFF);
        end
        got_a.delete();

        // Reset in the middle of a frame (start + 3 data bits of 0x81)
        bit_a(1'b0);
        bit_a(1'b1);
        bit_a(1'b0);
        bit_a(1'b0);
        rst  = 1'b1;
        rx_a = 1'b1;
        clk_wait(1);
        check("midrst busy", int'(busy_a), 0);
        check("midrst rx_data", int'(rx_data_a), 0);
        check("midrst rx_done", int'(rx_done_a), 0);
        check("midrst frame_err", int'(frame_err_a), 0);
        check("midrst parity_err", int'(parity_err_a), 0);
        rst = 1'b0;
        bit_a(1'b1);
        bit_a(1'b1);
        check("midrst no done", got_a.size(), 0);
        frame_a(8'h7E, 1'b1);
        bit_a(1'b1);
        bit_a(1'b1);
        expect_a("after rst", 8'h7E, 1'b0);

        // 7 data bits, 2 stop bits (parity bit present when the stage is built)
        got_b.delete();
        frame_b(7'h41, 1'b0, 1'b1, 1'b1);
        bit_b(1'b1);
        bit_b(1'b1);
        expect_b("b good parity", 7'h41, 1'b0, 1'b0);
        frame_b(7'h41, 1'b1, 1'b1, 1'b1);
        bit_b(1'b1);
        bit_b(1'b1);
        expect_b("b bad parity", 7'h41, 1'b0, ParOn);
        check("b held data", int'(rx_data_b), 'h41);
        frame_b(7'h41, 1'b0, 1'b1, 1'b0);
        bit_b(1'b1);
        bit_b(1'b1);
        expect_b("b low stop2", 7'h41, 1'b1, 1'b0);
        check("b busy", int'(busy_b), 0);

        check("rx_done never 2 clk", consec_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
